// File: rtl/param_prom_writer.sv
// Parameter PROM programmer: takes a byte stream over valid/ready and writes
// each byte with a timed WE_B strobe, advancing the PROM address with PARAM_CLK.
module param_prom_writer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned WR_PULSE  = 4,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_START,
  input  logic [15:0] WR_NBYTES,
  input  logic        WR_ABORT,
  input  logic [7:0]  DIN,
  input  logic        DIN_VALID,
  output logic        DIN_READY,
  output logic [7:0]  PARAM_DAT_O,
  output logic        PARAM_DAT_T,
  output logic        PARAM_WE_B,
  output logic        PARAM_CE_B,
  output logic        PARAM_OE,
  output logic        PARAM_CLK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] BYTES_WRITTEN
);

  typedef enum logic [3:0] {
    S_IDLE, S_CEON, S_WAIT, S_SETUP, S_STROBE,
    S_HOLD, S_ADV, S_FINISH, S_ABRT
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] PULSE_LAST = 16'(WR_PULSE - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic [15:0] nbytes;
  logic [7:0]  byte_q;
  logic        from_abrt;

  logic        start_ok;
  logic        accept;
  logic        abort_ok;
  logic        tmo;
  logic [15:0] bw_next;

  logic        ce_b_d;
  logic        dat_t_d;
  logic        we_b_d;
  logic        pclk_d;
  logic        rdy_d;
  logic        busy_d;
  logic        done_d;
  logic [7:0]  dat_d;

  assign start_ok = (state == S_IDLE) && WR_START && !BUSY;
  assign accept   = (state == S_WAIT) && DIN_READY && DIN_VALID;
  assign abort_ok = WR_ABORT && (state != S_IDLE) &&
                    (state != S_FINISH) && (state != S_ABRT);
  assign tmo      = (state == S_WAIT) && DIN_READY && !DIN_VALID &&
                    (cnt == TMO_LAST);
  assign bw_next  = BYTES_WRITTEN + 16'd1;
  assign PARAM_OE = 1'b0;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start_ok) nxt = (WR_NBYTES == 16'd0) ? S_FINISH : S_CEON;
      S_CEON:   if (cnt == SETUP_LAST) nxt = S_WAIT;
      S_WAIT: begin
        if (accept)   nxt = S_SETUP;
        else if (tmo) nxt = S_ABRT;
      end
      S_SETUP:  if (cnt == SETUP_LAST) nxt = S_STROBE;
      S_STROBE: if (cnt == PULSE_LAST) nxt = S_HOLD;
      S_HOLD:   if (cnt == HOLD_LAST) nxt = S_ADV;
      S_ADV:    nxt = (bw_next == nbytes) ? S_FINISH : S_WAIT;
      S_FINISH: nxt = S_IDLE;
      S_ABRT:   if (cnt == HOLD_LAST) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (abort_ok) nxt = S_ABRT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (state == S_WAIT) begin
        if (DIN_READY && !DIN_VALID) cnt <= cnt + 16'd1;
      end else if (state != S_IDLE)
        cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nbytes        <= '0;
      byte_q        <= '0;
      BYTES_WRITTEN <= '0;
      ERR           <= 1'b0;
      from_abrt     <= 1'b0;
    end else begin
      from_abrt <= (state == S_ABRT);
      if (start_ok) begin
        nbytes        <= WR_NBYTES;
        BYTES_WRITTEN <= '0;
        ERR           <= 1'b0;
      end else if (state == S_ADV)
        BYTES_WRITTEN <= bw_next;
      else if ((state == S_IDLE) && from_abrt)
        ERR <= 1'b1;
      if (accept) byte_q <= DIN;
    end
  end

  // Pins follow the state one cycle late so every output is a clean register.
  always_comb begin
    ce_b_d  = 1'b1;
    dat_t_d = 1'b1;
    we_b_d  = 1'b1;
    pclk_d  = 1'b0;
    rdy_d   = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    dat_d   = PARAM_DAT_O;
    unique case (state)
      S_IDLE:   busy_d = 1'b0;
      S_CEON:   ce_b_d = 1'b0;
      S_WAIT: begin
        ce_b_d = 1'b0;
        rdy_d  = (nxt == S_WAIT);
      end
      S_SETUP: begin
        ce_b_d  = 1'b0;
        dat_t_d = 1'b0;
        dat_d   = byte_q;
      end
      S_STROBE: begin
        ce_b_d  = 1'b0;
        dat_t_d = 1'b0;
        we_b_d  = 1'b0;
      end
      S_HOLD: begin
        ce_b_d  = 1'b0;
        dat_t_d = 1'b0;
      end
      S_ADV: begin
        ce_b_d = 1'b0;
        pclk_d = 1'b1;
      end
      S_FINISH: done_d = 1'b1;
      S_ABRT: begin
        ce_b_d  = 1'b0;
        dat_t_d = PARAM_DAT_T;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PARAM_DAT_O <= '0;
      PARAM_DAT_T <= 1'b1;
      PARAM_WE_B  <= 1'b1;
      PARAM_CE_B  <= 1'b1;
      PARAM_CLK   <= 1'b0;
      DIN_READY   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      PARAM_DAT_O <= dat_d;
      PARAM_DAT_T <= dat_t_d;
      PARAM_WE_B  <= we_b_d;
      PARAM_CE_B  <= ce_b_d;
      PARAM_CLK   <= pclk_d;
      DIN_READY   <= rdy_d;
      BUSY        <= busy_d;
      DONE        <= done_d;
    end
  end

endmodule

// File: tb/tb_param_prom_writer.sv
// Bench for param_prom_writer: random byte sessions checked against
// pin-level timing and data rules, plus abort, timeout and reset cases.
module tb_param_prom_writer;

  localparam int SETUP  = 2;
  localparam int PULSE  = 4;
  localparam int HOLD   = 2;
  localparam int TMO    = 16;
  localparam int PERIOD = SETUP + PULSE + HOLD + 2;

  logic        CLK;
  logic        RST;
  logic        WR_START;
  logic [15:0] WR_NBYTES;
  logic        WR_ABORT;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [7:0]  PARAM_DAT_O;
  logic        PARAM_DAT_T;
  logic        PARAM_WE_B;
  logic        PARAM_CE_B;
  logic        PARAM_OE;
  logic        PARAM_CLK;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] BYTES_WRITTEN;

  param_prom_writer #(
    .SETUP_CYC(SETUP), .WR_PULSE(PULSE),
    .HOLD_CYC(HOLD), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .WR_START(WR_START), .WR_NBYTES(WR_NBYTES),
    .WR_ABORT(WR_ABORT), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .PARAM_DAT_O(PARAM_DAT_O), .PARAM_DAT_T(PARAM_DAT_T),
    .PARAM_WE_B(PARAM_WE_B), .PARAM_CE_B(PARAM_CE_B),
    .PARAM_OE(PARAM_OE), .PARAM_CLK(PARAM_CLK),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .BYTES_WRITTEN(BYTES_WRITTEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int st_cyc = 0;
  int acc_cyc = 0;
  bit acc_pend = 0;
  bit abort_armed = 0;
  logic [7:0] expq[$];
  logic [7:0] srcq[$];
  logic [7:0] cur = 8'h00;
  logic we_prev = 1'b1;
  logic rdy_prev = 1'b0;
  int run = 0;
  int pulses = 0;
  int clk_cnt = 0;
  int clk_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rdy_hi = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr();
    expq.delete();
    pulses = 0;
    clk_cnt = 0;
    clk_cyc = 0;
    done_cnt = 0;
    done_cyc = 0;
    rdy_hi = 0;
    acc_pend = 0;
    abort_armed = 0;
  endtask

  // One clock: advance, sample #1 later, check pin rules and log events.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (!PARAM_DAT_T) begin
      check("inv_ce", PARAM_CE_B, 0);
      check("inv_oe", PARAM_OE, 0);
    end
    if (!PARAM_WE_B) check("inv_we_dat_t", PARAM_DAT_T, 0);
    if (PARAM_CLK) check("inv_clk_we", PARAM_WE_B, 1);
    if (!PARAM_WE_B && we_prev) begin
      pulses++;
      run = 1;
      check("we_lat", cyc - acc_cyc, SETUP + 1);
      if (expq.size() > 0) begin
        cur = expq.pop_front();
        check("strobe_dat", PARAM_DAT_O, cur);
      end else
        check("strobe_extra", 1, 0);
    end else if (!PARAM_WE_B) begin
      run++;
      check("dat_stable", PARAM_DAT_O, cur);
    end else if (we_prev == 1'b0 && !abort_armed)
      check("we_len", run, PULSE);
    if (PARAM_CLK) begin
      clk_cnt++;
      clk_cyc = cyc;
      check("clk_lat", cyc - acc_cyc, PERIOD - 1);
    end
    if (DIN_READY) rdy_hi++;
    if (DIN_READY && !rdy_prev && acc_pend) begin
      check("rdy_lat", cyc - acc_cyc, PERIOD);
      acc_pend = 0;
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
    we_prev = PARAM_WE_B;
    rdy_prev = DIN_READY;
  endtask

  task automatic start(input logic [15:0] n);
    WR_NBYTES = n;
    WR_START = 1'b1;
    tick();
    WR_START = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic push(input logic [7:0] b);
    DIN = b;
    DIN_VALID = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (DIN_READY) begin
        tick();
        acc_cyc = cyc;
        acc_pend = 1;
        expq.push_back(b);
        DIN_VALID = 1'b0;
        return;
      end
      tick();
    end
    check("ready_timeout", 0, 1);
    DIN_VALID = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (done_cnt > 0) return;
      tick();
    end
    check("done_timeout", done_cnt, 1);
  endtask

  task automatic session(input int n, input int max_gap,
                         input int stall_at, input int stall_len);
    logic [7:0] b;
    int gap;
    clr();
    start(16'(n));
    check("err_clr", ERR, 0);
    check("bw_clr", BYTES_WRITTEN, 0);
    check("ce_b_t", PARAM_CE_B, 1);
    tick();
    check("busy_t1", BUSY, 1);
    check("ce_b_t1", PARAM_CE_B, (n == 0) ? 1 : 0);
    if (n == 0) begin
      check("done_n0", DONE, 1);
      check("bw_n0", BYTES_WRITTEN, 0);
      tick();
      check("busy_n0", BUSY, 0);
      check("done_n0_1cyc", DONE, 0);
      check("ce_b_n0", PARAM_CE_B, 1);
      return;
    end
    tick();
    check("rdy_t2", DIN_READY, 0);
    tick();
    check("rdy_t3", DIN_READY, 1);
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (i == stall_at) gap += stall_len;
      for (int g = 0; g < gap; g++) begin
        tick();
        if (i == stall_at && i > 0 && cyc >= acc_cyc + PERIOD) begin
          check("stall_ce_b", PARAM_CE_B, 0);
          check("stall_dat_t", PARAM_DAT_T, 1);
        end
      end
      if (srcq.size() > 0) b = srcq.pop_front();
      else b = 8'($urandom);
      push(b);
    end
    wait_done(60);
    check("done_cnt", done_cnt, 1);
    check("done_lat", done_cyc - clk_cyc, 1);
    check("clk_cnt", clk_cnt, n);
    check("pulses", pulses, n);
    check("bw", BYTES_WRITTEN, n);
    check("err", ERR, 0);
    check("ce_b_done", PARAM_CE_B, 1);
    check("leftover", expq.size(), 0);
    tick();
    check("busy_end", BUSY, 0);
    check("done_1cyc", DONE, 0);
  endtask

  initial begin
    RST = 1'b1;
    WR_START = 1'b0;
    WR_NBYTES = '0;
    WR_ABORT = 1'b0;
    DIN = '0;
    DIN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    tick();
    check("rst_dat_o", PARAM_DAT_O, 0);
    check("rst_dat_t", PARAM_DAT_T, 1);
    check("rst_we_b", PARAM_WE_B, 1);
    check("rst_ce_b", PARAM_CE_B, 1);
    check("rst_oe", PARAM_OE, 0);
    check("rst_pclk", PARAM_CLK, 0);
    check("rst_ready", DIN_READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_bw", BYTES_WRITTEN, 0);

    srcq = '{8'hA5, 8'h5A, 8'hFF};
    session(3, 0, -1, 0);
    session(0, 0, -1, 0);
    session(4, 0, 2, 20);
    for (int r = 0; r < 4; r++)
      session(int'($urandom_range(1, 6)), 3, -1, 0);

    // abort in the second cycle of the second byte's strobe
    clr();
    start(16'd3);
    push(8'h11);
    push(8'h22);
    for (int k = 0; k < 20 && PARAM_WE_B; k++) tick();
    tick();
    check("abort_in_strobe", PARAM_WE_B, 0);
    abort_armed = 1;
    WR_ABORT = 1'b1;
    tick();
    WR_ABORT = 1'b0;
    tick();
    check("abort_we_b", PARAM_WE_B, 1);
    tick();
    tick();
    check("abort_err", ERR, 1);
    check("abort_busy", BUSY, 0);
    check("abort_bw", BYTES_WRITTEN, 1);
    check("abort_done", done_cnt, 0);
    check("abort_ce_b", PARAM_CE_B, 1);
    check("abort_dat_t", PARAM_DAT_T, 1);
    tick();

    // timeout with no data offered
    clr();
    start(16'd2);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!BUSY) break;
    end
    check("tmo_busy", BUSY, 0);
    check("tmo_ready_cycles", rdy_hi, TMO);
    check("tmo_err", ERR, 1);
    check("tmo_done", done_cnt, 0);
    check("tmo_bw", BYTES_WRITTEN, 0);
    session(1, 0, -1, 0);

    // a start while busy must not restart the session
    clr();
    start(16'd2);
    tick();
    WR_NBYTES = 16'd0;
    WR_START = 1'b1;
    tick();
    WR_START = 1'b0;
    push(8'hC3);
    push(8'h3C);
    wait_done(60);
    check("restart_bw", BYTES_WRITTEN, 2);
    check("restart_done", done_cnt, 1);
    check("restart_clk", clk_cnt, 2);
    tick();

    // asynchronous reset while the byte is in its hold phase
    clr();
    start(16'd2);
    push(8'h96);
    for (int k = 0; k < 20 && cyc < acc_cyc + PULSE + SETUP + 1; k++) tick();
    check("hold_we_b", PARAM_WE_B, 1);
    check("hold_dat_t", PARAM_DAT_T, 0);
    #2;
    RST = 1'b1;
    #1;
    check("arst_dat_t", PARAM_DAT_T, 1);
    check("arst_ce_b", PARAM_CE_B, 1);
    check("arst_we_b", PARAM_WE_B, 1);
    check("arst_busy", BUSY, 0);
    check("arst_bw", BYTES_WRITTEN, 0);
    #1;
    RST = 1'b0;
    we_prev = 1'b1;
    rdy_prev = 1'b0;
    tick();
    check("post_rst_busy", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_prom_writer.md
# param_prom_writer

Programs the on-board parameter PROM, the write-side counterpart of the auto-load path that reads constants from the same PROM bus (PARAM_DAT, PARAM_CLK, PARAM_CE_B, PARAM_OE). The block accepts a byte stream over a valid/ready handshake and writes each byte with a timed write-strobe cycle. After each byte it clocks the PROM's internal address counter once with PARAM_CLK. It sits between the configuration/JTAG user-register logic, which supplies bytes, and the PROM pad buffers. Bus direction is controlled through PARAM_DAT_T.

## Interface
- SETUP_CYC, 2: cycles data/CE are stable before the write strobe; also the CE-to-first-byte delay.
- WR_PULSE, 4: cycles PARAM_WE_B is held low per byte.
- HOLD_CYC, 2: cycles data stays driven after the strobe ends.
- TIMEOUT, 65535: WAIT-state cycles without DIN_VALID before an underrun abort. 16-bit counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_START  in  1  one-cycle pulse that starts a session. Ignored unless the block is IDLE.
- WR_NBYTES  in  16  number of bytes in the session, latched on WR_START.
- WR_ABORT  in  1  level; requests termination of the session.
- DIN  in  8  byte to write.
- DIN_VALID  in  1  DIN is valid.
- DIN_READY  out  1  block accepts DIN this cycle.
- PARAM_DAT_O  out  8  data driven to the PROM.
- PARAM_DAT_T  out  1  1 = pads tristated (input), 0 = driving.
- PARAM_WE_B  out  1  PROM write strobe, active low.
- PARAM_CE_B  out  1  PROM chip enable, active low.
- PARAM_OE  out  1  PROM output enable. Constant 0 in this block.
- PARAM_CLK  out  1  PROM address-advance clock.
- BUSY  out  1  session in progress.
- DONE  out  1  one-cycle pulse on normal completion.
- ERR  out  1  sticky error flag; set by abort or timeout, cleared by the next accepted WR_START.
- BYTES_WRITTEN  out  16  count of completed byte writes in the current or last session.

## Operation
- All outputs are registered. Reset values:
  - PARAM_DAT_O=0, PARAM_DAT_T=1, PARAM_WE_B=1, PARAM_CE_B=1, PARAM_OE=0, PARAM_CLK=0.
  - DIN_READY=0, BUSY=0, DONE=0, ERR=0, BYTES_WRITTEN=0.
- States:
  - IDLE: on WR_START, latch WR_NBYTES, clear ERR and BYTES_WRITTEN. If NBYTES=0, go to FINISH; otherwise go to CEON.
  - CEON: CE_B=0 for SETUP_CYC cycles, then go to WAIT.
  - WAIT: DIN_READY=1. On DIN_VALID, latch DIN and go to SETUP. The timeout counter runs only in WAIT and resets on each accepted byte.
  - SETUP: DAT_T=0, data driven, WE_B=1, for SETUP_CYC cycles.
  - STROBE: WE_B=0 for WR_PULSE cycles.
  - HOLD: WE_B=1, data still driven, for HOLD_CYC cycles.
  - ADV: DAT_T=1, PARAM_CLK=1 for 1 cycle, BYTES_WRITTEN+1. If BYTES_WRITTEN reaches NBYTES, go to FINISH; otherwise go to WAIT.
  - FINISH: CE_B=1, DAT_T=1, DONE=1 for 1 cycle, then go to IDLE.
  - ABRT: WE_B=1, DAT_T holds its value for HOLD_CYC cycles, then DAT_T=1, CE_B=1, ERR=1, go to IDLE. No DONE pulse.
- Abort and timeout:
  - WR_ABORT in any state except IDLE/FINISH/ABRT goes to ABRT on the next edge. This cuts any strobe short.
  - TIMEOUT expiry in WAIT also goes to ABRT.
  - A byte already latched but not yet through ADV is not counted.
- Invariants:
  - PARAM_DAT_T=0 implies PARAM_OE=0 and PARAM_CE_B=0.
  - PARAM_WE_B=0 only while DAT_T=0.
  - PARAM_CLK and WE_B are never both active.
- BUSY=1 in every state except IDLE.
- A WR_START arriving while BUSY is dropped; it does not affect the current session.
- BYTES_WRITTEN is unsigned 16-bit and cannot wrap, because it is bounded by NBYTES.

## Timing
- WR_START accepted at edge t: CE_B falls at t+1, DIN_READY rises at t+1+SETUP_CYC (t+3 at defaults).
- Byte accepted at edge h:
  - DAT_T falls at h+1.
  - WE_B is low over cycles h+1+SETUP_CYC … h+SETUP_CYC+WR_PULSE (h+3..h+6 at defaults).
  - PARAM_CLK pulses at h+SETUP_CYC+WR_PULSE+HOLD_CYC+1 (h+9).
  - DIN_READY returns at h+10.
- Byte period is SETUP_CYC+WR_PULSE+HOLD_CYC+2 cycles (10 at defaults).
- Last ADV at edge a: DONE=1 and CE_B=1 at a+1, BUSY=0 at a+2.
- WR_ABORT sampled at edge b: WE_B=1 at b+1. ERR=1 and BUSY=0 after b+1+HOLD_CYC.
- RST asserted mid-session forces all reset values immediately, without waiting for a clock edge.

## Test plan
- NBYTES=3, bytes 0xA5,0x5A,0xFF supplied back-to-back → three WE_B pulses 4 cycles long, three PARAM_CLK pulses, DATA_O matches each byte during its strobe, BYTES_WRITTEN=3, DONE pulse, ERR=0.
- NBYTES=0 → no CE_B assertion, DONE pulses 1 cycle after start, BYTES_WRITTEN=0.
- NBYTES=4, DIN_VALID stalls 20 cycles after byte 2 → pins stay idle during the stall (CE_B=0, DAT_T=1), then resume; total 4 bytes, DONE.
- WR_ABORT asserted in cycle 2 of STROBE on byte 2 → WE_B high next cycle, ERR=1, BYTES_WRITTEN=1, no DONE, CE_B=1 at end.
- TIMEOUT=16, no DIN_VALID after start → abort 16 cycles after READY, ERR=1; next WR_START clears ERR.
- RST pulse during HOLD → DAT_T=1, CE_B=1, WE_B=1 asynchronously. A WR_START while BUSY does not restart the session.
